// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory waits, mul/div
// occupancy of EX, branch redirects, load-use hazards and fetch waits.
module pipeline_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        ex_md_start,
    input  logic        imem_ready,
    input  logic        mem_dmem_req,
    input  logic        mem_dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        ex_mem_flush,
    output logic        mem_wb_stall,
    output logic        mem_wb_flush,
    output logic        pc_redirect,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               dmem_wait;
    logic               md_hold;
    logic               load_use;

    assign dmem_wait = mem_dmem_req & ~mem_dmem_ready;
    assign md_hold   = ((state == RUN) & ex_md_start) | ((state == MD_WAIT) & (cnt != '0));
    assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign md_busy   = (state == MD_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= 32'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (pc_stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    always_comb begin
        next_state   = state;
        cnt_next     = cnt;
        md_done      = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_stall = 1'b0;
        mem_wb_flush = 1'b0;
        pc_redirect  = 1'b0;

        // A memory wait holds the op in RUN so it is re-presented; once in MD_WAIT
        // the counter keeps running and done is held until MEM releases.
        case (state)
            RUN: begin
                if (ex_md_start && !dmem_wait) begin
                    next_state = MD_WAIT;
                    cnt_next   = CNT_W'(MD_LATENCY - 2);
                end
            end
            MD_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    md_done = 1'b1;
                    if (!dmem_wait) begin
                        next_state = RUN;
                    end
                end
            end
            default: next_state = RUN;
        endcase

        if (rst) begin
            md_done      = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (dmem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (md_hold) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            pc_redirect  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (!imem_ready) begin
            pc_stall     = 1'b1;
            if_id_flush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a vector table for single-cycle hazard
// priority plus hand-written mul/div, memory-wait, fetch-wait and reset sequences.
module tb_pipeline_ctrl;

    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 4;

    // Output bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    // ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, pc_redirect, md_busy, md_done
    localparam logic [11:0] E_NONE = 12'b0000_0000_0000;
    localparam logic [11:0] E_DMEM = 12'b1101_0100_1000;
    localparam logic [11:0] E_MD   = 12'b1101_0010_0000;
    localparam logic [11:0] E_BR   = 12'b0010_1000_0100;
    localparam logic [11:0] E_LU   = 12'b1100_1000_0000;
    localparam logic [11:0] E_IM   = 12'b1010_0000_0000;
    localparam logic [11:0] E_RST  = 12'b0010_1010_1000;
    localparam logic [11:0] BUSY   = 12'b0000_0000_0010;
    localparam logic [11:0] DONE   = 12'b0000_0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic        ex_mem_read = 1'b0, ex_branch_taken = 1'b0, ex_md_start = 1'b0;
    logic        imem_ready = 1'b1, mem_dmem_req = 1'b0, mem_dmem_ready = 1'b0;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
    logic        pc_redirect, md_busy, md_done;
    logic [31:0] stall_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 32'd0;
    logic [11:0] exp_q[$];
    string       tag_q[$];

    typedef struct {
        logic       r;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       md;
        logic       imr;
        logic       dreq;
        logic       drdy;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[15];

    pipeline_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .imem_ready(imem_ready), .mem_dmem_req(mem_dmem_req), .mem_dmem_ready(mem_dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
        .pc_redirect(pc_redirect), .md_busy(md_busy), .md_done(md_done),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic bt, input logic md, input logic imr,
                                 input logic dreq, input logic drdy, input logic [11:0] exp);
        vec_t v;
        v.r = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mr = mr; v.bt = bt; v.md = md; v.imr = imr; v.dreq = dreq; v.drdy = drdy;
        v.exp = exp;
        return v;
    endfunction

    // Control-only vector for the multi-cycle sequences: no register hazards, fetch ready
    function automatic vec_t ctl(input logic r, input logic md, input logic bt,
                                 input logic dreq, input logic drdy, input logic [11:0] exp);
        return mkv(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, bt, md, 1'b1, dreq, drdy, exp);
    endfunction

    task automatic applyStimulus(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        rst             = v.r;
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        ex_rd           = v.rd;
        ex_mem_read     = v.mr;
        ex_branch_taken = v.bt;
        ex_md_start     = v.md;
        imem_ready      = v.imr;
        mem_dmem_req    = v.dreq;
        mem_dmem_ready  = v.drdy;
        exp_q.push_back(v.exp);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        logic [11:0] exp;
        logic [11:0] got;
        string       tag;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue required one entry");
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                   ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush,
                   pc_redirect, md_busy, md_done};
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s outs: got %b required %b", tag, got, exp);
            end
            checks++;
            if (stall_count !== model_cnt) begin
                errors++;
                $display("[TB] FAIL %s stall_count: got %0d required %0d", tag, stall_count, model_cnt);
            end
            if (rst) model_cnt = 32'd0;
            else if (exp[11]) model_cnt = model_cnt + 32'd1;
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        applyStimulus(v, tag);
        checkOutput();
    endtask

    initial begin
        //            r  rs1   rs2   u1 u2 rd    mr bt md imr dq dr  expected
        vecs[0]  = mkv(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 1, 0, 0, E_RST);
        vecs[1]  = mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, E_NONE);
        vecs[2]  = mkv(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, 0, 0, E_LU);
        vecs[3]  = mkv(0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 1, 0, 0, E_NONE);
        vecs[4]  = mkv(0, 5'd3, 5'd7, 0, 1, 5'd7, 1, 0, 0, 1, 0, 0, E_LU);
        vecs[5]  = mkv(0, 5'd3, 5'd7, 0, 0, 5'd7, 1, 0, 0, 1, 0, 0, E_NONE);
        vecs[6]  = mkv(0, 5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 1, 0, 0, E_NONE);
        vecs[7]  = mkv(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 1, 0, 0, E_BR);
        vecs[8]  = mkv(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0, 0, E_LU);
        vecs[9]  = mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, E_IM);
        vecs[10] = mkv(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 1, 0, E_DMEM);
        vecs[11] = mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 1, E_NONE);
        vecs[12] = mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, 0, E_DMEM);
        vecs[13] = mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0, 0, E_BR);
        vecs[14] = mkv(0, 5'd6, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, 0, 0, E_NONE);

        for (int i = 0; i < 15; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // Unobstructed mul/div: hold cycles 0..2, done on cycle 3, branch ignored while held
        run(ctl(0, 1, 0, 0, 0, E_MD),        "md_c0");
        run(ctl(0, 1, 0, 0, 0, E_MD | BUSY), "md_c1");
        run(ctl(0, 1, 1, 0, 0, E_MD | BUSY), "md_c2_branch");
        run(ctl(0, 1, 0, 0, 0, BUSY | DONE), "md_c3_done");
        run(ctl(0, 0, 0, 0, 0, E_NONE),      "md_c4_run");

        // Data-memory wait while done is pending keeps MD_WAIT and done high
        run(ctl(0, 1, 0, 0, 0, E_MD),               "mdw_c0");
        run(ctl(0, 1, 0, 0, 0, E_MD | BUSY),        "mdw_c1");
        run(ctl(0, 1, 0, 0, 0, E_MD | BUSY),        "mdw_c2");
        for (int i = 0; i < 3; i++) begin
            run(ctl(0, 1, 0, 1, 0, E_DMEM | BUSY | DONE), $sformatf("mdw_wait%0d", i));
        end
        run(ctl(0, 1, 0, 1, 1, BUSY | DONE),        "mdw_release");
        run(ctl(0, 0, 0, 0, 0, E_NONE),             "mdw_run");

        // Fetch wait for two cycles; the idle cycle after confirms the counter moved by 2
        run(mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, E_IM), "imem_w0");
        run(mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, E_IM), "imem_w1");
        run(ctl(0, 0, 0, 0, 0, E_NONE), "imem_after");

        // Reset with cnt=2 aborts the op without a done pulse
        run(ctl(0, 1, 0, 0, 0, E_MD),         "rstmd_c0");
        run(ctl(1, 1, 0, 0, 0, E_RST | BUSY), "rstmd_reset");
        run(ctl(0, 0, 0, 0, 0, E_NONE),       "rstmd_after");
        run(ctl(0, 0, 0, 0, 0, E_NONE),       "rstmd_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the stall and flush inputs of the if_id, id_ex, ex_mem and mem_wb pipeline registers and the PC hold. Resolves load-use hazards, taken-branch redirects, instruction-fetch wait, data-memory wait and multi-cycle mul/div occupancy of EX. A small FSM with a latency counter handles the multi-cycle ops.

Parameters:
MD_LATENCY, 4, total cycles a mul/div op occupies EX (legal range 2..16)
CNT_W, 4, width of the mul/div down-counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination index of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump
ex_md_start  in  1  EX holds a mul/div op
imem_ready  in  1  fetch data valid this cycle
mem_dmem_req  in  1  MEM stage issues a data access
mem_dmem_ready  in  1  data access completes this cycle
pc_stall  out  1  hold PC
if_id_stall, if_id_flush  out  1 each  if_id register control
id_ex_stall, id_ex_flush  out  1 each  id_ex register control
ex_mem_stall, ex_mem_flush  out  1 each  ex_mem register control
mem_wb_stall, mem_wb_flush  out  1 each  mem_wb register control
pc_redirect  out  1  take branch target this cycle
md_busy  out  1  FSM in MD_WAIT
md_done  out  1  mul/div result valid this cycle
stall_count  out  32  cycles with pc_stall=1 since reset

Behaviour:
- Stall/flush outputs are combinational from inputs and state. Each takes effect at the next rising edge. A register seeing both stall and flush clears (flush wins).
- rst (sampled at edge): state<=RUN, cnt<=0, stall_count<=0. While rst=1: all *_flush=1, all *_stall=0, pc_redirect=0, md_done=0.
- Internal terms:
  - dmem_wait = mem_dmem_req & ~mem_dmem_ready
  - md_hold = (RUN & ex_md_start) | (MD_WAIT & cnt!=0)
  - load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- Priority, highest first; exactly one case applies:
  1. dmem_wait: pc, if_id, id_ex, ex_mem stall; mem_wb_flush=1.
  2. md_hold: pc, if_id, id_ex stall; ex_mem_flush=1.
  3. ex_branch_taken: pc_redirect=1; if_id_flush=1, id_ex_flush=1; no stalls.
  4. load_use: pc, if_id stall; id_ex_flush=1.
  5. ~imem_ready: pc_stall=1; if_id_flush=1.
  6. Otherwise all zero.
- pc_redirect=1 only in case 3. A taken branch under cases 1/2 stays in EX and redirects once released.
- FSM RUN:
  - If ex_md_start & ~dmem_wait: cnt<=MD_LATENCY-2, go MD_WAIT.
  - If ex_md_start & dmem_wait: stay RUN (op re-presented next cycle).
- FSM MD_WAIT:
  - cnt decrements each cycle while nonzero, regardless of dmem_wait; saturates at 0.
  - At cnt==0: md_done=1, md_hold=0.
  - If ~dmem_wait: go RUN.
  - If dmem_wait: stay MD_WAIT, cnt=0, md_done stays 1.
- EX occupancy for an unobstructed mul/div is exactly MD_LATENCY cycles. MD_LATENCY=2 enters MD_WAIT with cnt=0 (done the next cycle).
- md_busy = (state==MD_WAIT).
- stall_count increments each non-reset cycle with pc_stall=1; wraps at 2^32-1 to 0.
- Reset asserted in MD_WAIT aborts the op: RUN next cycle, no md_done.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 for one cycle. Same with ex_rd=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 with load_use true -> pc_redirect=1, if_id_flush=id_ex_flush=1, pc_stall=0.
- Mul/div, MD_LATENCY=4: ex_md_start held -> id_ex_stall=1 for cycles 0..2, md_done=1 on cycle 3, md_busy cycles 1..3, then state RUN.
- Dmem wait during MD_WAIT cnt==0: mem_dmem_ready=0 for 3 cycles -> ex_mem_stall=1, mem_wb_flush=1, md_done stays 1 for all 3 cycles. RUN after ready.
- imem_ready=0 for 2 cycles with no hazards -> pc_stall=1, if_id_flush=1 both cycles; stall_count advances by 2.
- rst=1 mid-MD_WAIT (cnt=2) -> all flushes=1 during reset; next cycle md_busy=0, stall_count=0, md_done never pulses.
